// File: rtl/jpeg_bitstream_packer.sv
// ---------------------------------------------------------------------------
// jpeg_bitstream_packer
//
// Packs the variable-length fields of one Huffman symbol record (optional DC
// code + amplitude, then AC code + amplitude) MSB-first into a 32-bit
// accumulator and drains it as a byte stream. Every emitted 0xFF is followed
// by a stuffed 0x00. A flush pads the final partial byte with 1-bits, drains
// everything and pulses flush_done.
//
// Configuration macro: JPEG_BYTE_STUFF_EN
//   defined   : 0x00 is inserted after every emitted 0xFF
//   undefined : no stuffing logic; 0xFF passes through raw
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   sym_valid/sym_ready   symbol strobe / ready (ready only in IDLE)
//   blk_end               symbol closes a block (EOB)
//   dc_code, dc_code_len  DC Huffman code (right-justified) and length
//   dc_amp, dc_amp_len    DC amplitude bits and length
//   ac_code, ac_code_len  AC Huffman code and length
//   ac_amp, ac_amp_len    AC amplitude bits and length
//   flush / flush_done    end-of-image drain request / completion pulse
//   byte_out/byte_valid/byte_ready  output byte handshake
//   busy                  anything in flight
//   err_overflow          sticky: symbol strobe while not ready
//   blocks_done           count of accepted blk_end symbols (wraps)
// ---------------------------------------------------------------------------
module jpeg_bitstream_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        sym_valid,
  output logic        sym_ready,
  input  logic        blk_end,
  input  logic [8:0]  dc_code,
  input  logic [7:0]  dc_code_len,
  input  logic [7:0]  dc_amp,
  input  logic [7:0]  dc_amp_len,
  input  logic [15:0] ac_code,
  input  logic [7:0]  ac_code_len,
  input  logic [7:0]  ac_amp,
  input  logic [7:0]  ac_amp_len,
  input  logic        flush,
  output logic        flush_done,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        busy,
  output logic        err_overflow,
  output logic [15:0] blocks_done
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_DC_CODE    = 3'd1;
  localparam logic [2:0] S_DC_AMP     = 3'd2;
  localparam logic [2:0] S_AC_CODE    = 3'd3;
  localparam logic [2:0] S_AC_AMP     = 3'd4;
  localparam logic [2:0] S_FLUSH_PAD  = 3'd5;
  localparam logic [2:0] S_FLUSH_WAIT = 3'd6;

  logic [2:0]  state;
  logic [31:0] acc;          // valid bits left-justified, zeros below
  logic [5:0]  count;        // 0..32 bits held in acc
  logic        dc_pending;

  logic [8:0]  cap_dc_code;
  logic [7:0]  cap_dc_code_len;
  logic [7:0]  cap_dc_amp;
  logic [7:0]  cap_dc_amp_len;
  logic [15:0] cap_ac_code;
  logic [7:0]  cap_ac_code_len;
  logic [7:0]  cap_ac_amp;
  logic [7:0]  cap_ac_amp_len;
  logic        cap_blk_end;

  function automatic logic [4:0] clamp_len(input logic [7:0] len, input logic [4:0] lim);
    return (len > {3'b000, lim}) ? lim : len[4:0];
  endfunction

  // Field presented by the current append state
  logic [15:0] fld;
  logic [4:0]  fld_len;
  logic        app_state;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    fld       = '0;
    fld_len   = '0;
    app_state = 1'b0;
    case (state)
      S_DC_CODE: begin
        fld       = {7'b0, cap_dc_code};
        fld_len   = clamp_len(cap_dc_code_len, 5'd9);
        app_state = 1'b1;
      end
      S_DC_AMP: begin
        fld       = {8'b0, cap_dc_amp};
        fld_len   = clamp_len(cap_dc_amp_len, 5'd8);
        app_state = 1'b1;
      end
      S_AC_CODE: begin
        fld       = cap_ac_code;
        fld_len   = clamp_len(cap_ac_code_len, 5'd16);
        app_state = 1'b1;
      end
      S_AC_AMP: begin
        fld       = {8'b0, cap_ac_amp};
        fld_len   = clamp_len(cap_ac_amp_len, 5'd8);
        app_state = 1'b1;
      end
      S_FLUSH_PAD: begin
        // (8 - count mod 8) mod 8 ones: negation in 3 bits gives exactly that
        fld       = 16'hFFFF;
        fld_len   = {2'b00, 3'd0 - count[2:0]};
        app_state = 1'b1;
      end
      default: ;
    endcase
  end

  // With count <= 16 and len <= 16 the field always fits below the held bits
  logic        do_append;
  logic [31:0] fld_mask;
  logic [31:0] fld_bits;
  logic [5:0]  fld_shift;
  logic [31:0] acc_app;
  logic [5:0]  cnt_app;

  assign do_append = app_state && (count <= 6'd16);
  assign fld_mask  = (32'd1 << fld_len) - 32'd1;
  assign fld_bits  = {16'b0, fld} & fld_mask;
  assign fld_shift = 6'd32 - count - {1'b0, fld_len};
  assign acc_app   = do_append ? (acc | (fld_bits << fld_shift)) : acc;
  assign cnt_app   = do_append ? (count + {1'b0, fld_len}) : count;

  // Output slot is free when empty or being accepted this cycle, so the
  // drain can look at the post-append bits and sustain one byte per cycle.
  logic slot_free;
  logic stuff_pending;
  logic stuff_req;
  logic sp_n;
  assign slot_free = !byte_valid || byte_ready;

`ifdef JPEG_BYTE_STUFF_EN
  logic ff_accept;
  assign ff_accept = byte_valid && byte_ready && (byte_out == 8'hFF);
  // The 0x00 is loaded in the same cycle its 0xFF is taken; stuff_pending
  // only carries the request if the slot could not take it.
  assign stuff_req = stuff_pending || ff_accept;
  assign sp_n      = stuff_req && !slot_free;

  always_ff @(posedge clock) begin
    if (reset) stuff_pending <= 1'b0;
    else       stuff_pending <= sp_n;
  end
`else
  assign stuff_pending = 1'b0;
  assign stuff_req     = 1'b0;
  assign sp_n          = 1'b0;
`endif

  logic        drain;
  logic [31:0] acc_n;
  logic [5:0]  cnt_n;
  logic        bv_n;
  logic [7:0]  bo_n;
  logic        flush_idle;

  always_comb begin
    drain = slot_free && !stuff_req && (cnt_app >= 6'd8);
    acc_n = drain ? (acc_app << 8) : acc_app;
    cnt_n = drain ? (cnt_app - 6'd8) : cnt_app;
    bv_n  = slot_free ? (stuff_req || drain) : 1'b1;
    bo_n  = byte_out;
    if (slot_free && stuff_req) bo_n = 8'h00;
    else if (drain)             bo_n = acc_app[31:24];
  end

  // Flush completes the cycle after the last byte handshake
  assign flush_idle = (cnt_n == 6'd0) && !bv_n && !sp_n;

  assign sym_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE) || (count != 6'd0) || byte_valid || stuff_pending;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= S_IDLE;
      acc             <= '0;
      count           <= '0;
      dc_pending      <= 1'b1;
      byte_out        <= '0;
      byte_valid      <= 1'b0;
      flush_done      <= 1'b0;
      err_overflow    <= 1'b0;
      blocks_done     <= '0;
      cap_dc_code     <= '0;
      cap_dc_code_len <= '0;
      cap_dc_amp      <= '0;
      cap_dc_amp_len  <= '0;
      cap_ac_code     <= '0;
      cap_ac_code_len <= '0;
      cap_ac_amp      <= '0;
      cap_ac_amp_len  <= '0;
      cap_blk_end     <= 1'b0;
    end else begin
      acc        <= acc_n;
      count      <= cnt_n;
      byte_out   <= bo_n;
      byte_valid <= bv_n;
      flush_done <= 1'b0;
      if (sym_valid && !sym_ready) err_overflow <= 1'b1;

      case (state)
        S_IDLE: begin
          if (flush) begin
            state <= S_FLUSH_PAD;
          end else if (sym_valid) begin
            cap_dc_code     <= dc_code;
            cap_dc_code_len <= dc_code_len;
            cap_dc_amp      <= dc_amp;
            cap_dc_amp_len  <= dc_amp_len;
            cap_ac_code     <= ac_code;
            cap_ac_code_len <= ac_code_len;
            cap_ac_amp      <= ac_amp;
            cap_ac_amp_len  <= ac_amp_len;
            cap_blk_end     <= blk_end;
            state           <= dc_pending ? S_DC_CODE : S_AC_CODE;
          end
        end
        S_DC_CODE: if (do_append) state <= S_DC_AMP;
        S_DC_AMP: begin
          if (do_append) begin
            state      <= S_AC_CODE;
            dc_pending <= 1'b0;
          end
        end
        S_AC_CODE: if (do_append) state <= S_AC_AMP;
        S_AC_AMP: begin
          if (do_append) begin
            state <= S_IDLE;
            if (cap_blk_end) begin
              dc_pending  <= 1'b1;
              blocks_done <= blocks_done + 16'd1;
            end
          end
        end
        S_FLUSH_PAD: if (do_append) state <= S_FLUSH_WAIT;
        S_FLUSH_WAIT: begin
          if (flush_idle) begin
            flush_done <= 1'b1;
            dc_pending <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_bitstream_packer.sv
// ---------------------------------------------------------------------------
// tb_jpeg_bitstream_packer
//
// Self-checking bench for jpeg_bitstream_packer. A bit-queue reference model
// turns each symbol into its MSB-first bit string, packs bytes and inserts
// stuffing when JPEG_BYTE_STUFF_EN is defined. A negedge monitor collects
// every byte handshake; streams are compared after each flush.
// ---------------------------------------------------------------------------
module tb_jpeg_bitstream_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic        sym_valid;
  logic        sym_ready;
  logic        blk_end;
  logic [8:0]  dc_code;
  logic [7:0]  dc_code_len;
  logic [7:0]  dc_amp;
  logic [7:0]  dc_amp_len;
  logic [15:0] ac_code;
  logic [7:0]  ac_code_len;
  logic [7:0]  ac_amp;
  logic [7:0]  ac_amp_len;
  logic        flush;
  logic        flush_done;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        busy;
  logic        err_overflow;
  logic [15:0] blocks_done;

  jpeg_bitstream_packer dut (
    .clock       (clock),
    .reset       (reset),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .blk_end     (blk_end),
    .dc_code     (dc_code),
    .dc_code_len (dc_code_len),
    .dc_amp      (dc_amp),
    .dc_amp_len  (dc_amp_len),
    .ac_code     (ac_code),
    .ac_code_len (ac_code_len),
    .ac_amp      (ac_amp),
    .ac_amp_len  (ac_amp_len),
    .flush       (flush),
    .flush_done  (flush_done),
    .byte_out    (byte_out),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .busy        (busy),
    .err_overflow(err_overflow),
    .blocks_done (blocks_done)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit         m_bits[$];
  logic [7:0] exp_q[$];
  logic [7:0] act_q[$];
  bit         m_dc_pending;
  int         m_blocks;

  always @(negedge clock)
    if (!reset && byte_valid && byte_ready) act_q.push_back(byte_out);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_pack();
    logic [7:0] b;
    while (m_bits.size() >= 8) begin
      b = '0;
      for (int i = 0; i < 8; i++) b = {b[6:0], m_bits.pop_front()};
      exp_q.push_back(b);
`ifdef JPEG_BYTE_STUFF_EN
      if (b == 8'hFF) exp_q.push_back(8'h00);
`endif
    end
  endtask

  task automatic model_push(input logic [15:0] val, input int len);
    for (int i = len - 1; i >= 0; i--) m_bits.push_back(val[i]);
    model_pack();
  endtask

  task automatic model_reset();
    m_bits.delete();
    exp_q.delete();
    act_q.delete();
    m_dc_pending = 1'b1;
    m_blocks     = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!sym_ready && n < 2000) begin
      @(posedge clock); #1;
      n++;
    end
    check(tag, sym_ready, 1'b1);
  endtask

  task automatic send_sym(input logic [8:0] dc, input logic [7:0] dcl,
                          input logic [7:0] dca, input logic [7:0] dcal,
                          input logic [15:0] ac, input logic [7:0] acl,
                          input logic [7:0] aca, input logic [7:0] acal,
                          input logic be);
    wait_idle("sym_ready_wait");
    dc_code = dc; dc_code_len = dcl; dc_amp = dca; dc_amp_len = dcal;
    ac_code = ac; ac_code_len = acl; ac_amp = aca; ac_amp_len = acal;
    blk_end = be;
    sym_valid = 1'b1;
    @(posedge clock); #1;
    sym_valid = 1'b0;
    if (m_dc_pending) begin
      model_push({7'b0, dc}, min_int(int'(dcl), 9));
      model_push({8'b0, dca}, min_int(int'(dcal), 8));
      m_dc_pending = 1'b0;
    end
    model_push(ac, min_int(int'(acl), 16));
    model_push({8'b0, aca}, min_int(int'(acal), 8));
    if (be) begin
      m_dc_pending = 1'b1;
      m_blocks     = (m_blocks + 1) % 65536;
    end
  endtask

  task automatic do_flush(input string tag);
    int n = 0;
    wait_idle({tag, "_idle"});
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    while (m_bits.size() % 8 != 0) m_bits.push_back(1'b1);
    model_pack();
    m_dc_pending = 1'b1;
    while (!flush_done && n < 2000) begin
      @(posedge clock); #1;
      n++;
    end
    check({tag, "_flush_done"}, flush_done, 1'b1);
    @(posedge clock); #1;
    check({tag, "_flush_pulse"}, flush_done, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, "_len"}, act_q.size(), exp_q.size());
    n = min_int(act_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) check({tag, "_byte"}, act_q[i], exp_q[i]);
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [7:0] first;
    int         n_stuff;
    bit         rand_done;

    reset = 1'b1; sym_valid = 1'b0; blk_end = 1'b0; flush = 1'b0;
    dc_code = '0; dc_code_len = '0; dc_amp = '0; dc_amp_len = '0;
    ac_code = '0; ac_code_len = '0; ac_amp = '0; ac_amp_len = '0;
    byte_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_byte_valid", byte_valid, 1'b0);
    check("rst_byte_out", byte_out, 8'h00);
    check("rst_sym_ready", sym_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_flush_done", flush_done, 1'b0);
    check("rst_err", err_overflow, 1'b0);
    check("rst_blocks", blocks_done, 16'd0);
    reset = 1'b0;
    model_reset();

    // Minimal block: 00 1100 + pad 11 -> 0x33
    send_sym(9'h000, 8'd2, 8'h00, 8'd0, 16'h000C, 8'd4, 8'h00, 8'd0, 1'b1);
    do_flush("minimal");
    first = (act_q.size() > 0) ? act_q[0] : 8'hxx;
    check("minimal_byte", first, 8'h33);
    check("minimal_blocks", blocks_done, 16'd1);
    compare_stream("minimal");

    // Stuffing: a lone 0xFF
    send_sym(9'h0FF, 8'd8, 8'h00, 8'd0, 16'h0000, 8'd0, 8'h00, 8'd0, 1'b0);
    do_flush("stuff");
`ifdef JPEG_BYTE_STUFF_EN
    n_stuff = 2;
`else
    n_stuff = 1;
`endif
    check("stuff_count", act_q.size(), n_stuff);
    compare_stream("stuff");

    // DC sequencing: DC in symbols 1 and 3 only
    send_sym(9'h1A5, 8'd9, 8'h5A, 8'd7, 16'h0003, 8'd2, 8'h05, 8'd3, 1'b0);
    send_sym(9'h0F0, 8'd6, 8'h33, 8'd5, 16'h00AB, 8'd8, 8'h01, 8'd1, 1'b1);
    send_sym(9'h155, 8'd9, 8'hC3, 8'd8, 16'h1234, 8'd13, 8'h7E, 8'd6, 1'b0);
    do_flush("dcseq");
    compare_stream("dcseq");
    check("dcseq_blocks", blocks_done, m_blocks);

    // Backpressure: byte_ready low for 20 cycles, 24-bit AC symbols
    byte_ready = 1'b0;
    fork
      begin
        repeat (20) @(posedge clock);
        #1 byte_ready = 1'b1;
      end
      begin
        send_sym(9'h000, 8'd0, 8'h00, 8'd0, 16'($urandom), 8'd16, 8'($urandom), 8'd8, 1'b0);
        send_sym(9'h000, 8'd0, 8'h00, 8'd0, 16'($urandom), 8'd16, 8'($urandom), 8'd8, 1'b0);
        repeat (4) @(posedge clock);
        #1;
        check("bp_sym_ready_low", sym_ready, 1'b0);
        send_sym(9'h000, 8'd0, 8'h00, 8'd0, 16'($urandom), 8'd16, 8'($urandom), 8'd8, 1'b0);
        send_sym(9'h000, 8'd0, 8'h00, 8'd0, 16'($urandom), 8'd16, 8'($urandom), 8'd8, 1'b1);
      end
    join
    do_flush("bp");
    compare_stream("bp");
    check("bp_err", err_overflow, 1'b0);

    // Randomized symbols (lengths beyond the clamps included) with random byte_ready
    rand_done = 1'b0;
    fork
      begin
        while (!rand_done) begin
          @(posedge clock); #1;
          byte_ready = ($urandom_range(0, 3) != 0);
        end
        byte_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 40; i++)
          send_sym(9'($urandom), 8'($urandom_range(0, 12)), 8'($urandom), 8'($urandom_range(0, 10)),
                   16'($urandom), 8'($urandom_range(0, 20)), 8'($urandom), 8'($urandom_range(0, 10)),
                   1'($urandom_range(0, 1)));
        rand_done = 1'b1;
      end
    join
    do_flush("rand");
    compare_stream("rand");
    check("rand_blocks", blocks_done, m_blocks);
    check("rand_err", err_overflow, 1'b0);

    // Overflow: strobe one cycle after an accept is dropped
    send_sym(9'h0A5, 8'd9, 8'h3C, 8'd6, 16'h0BEE, 8'd12, 8'h11, 8'd5, 1'b0);
    dc_code = 9'h1FF; dc_code_len = 8'd9; ac_code = 16'hFFFF; ac_code_len = 8'd16;
    sym_valid = 1'b1;
    @(posedge clock); #1;
    sym_valid = 1'b0;
    check("ovf_set", err_overflow, 1'b1);
    send_sym(9'h012, 8'd5, 8'h02, 8'd2, 16'h0071, 8'd7, 8'h09, 8'd4, 1'b1);
    do_flush("ovf");
    compare_stream("ovf");
    check("ovf_sticky", err_overflow, 1'b1);

    // Reset mid-stream with count = 12 and a byte held
    byte_ready = 1'b0;
    send_sym(9'h000, 8'd0, 8'h00, 8'd0, 16'hA5C3, 8'd16, 8'h0B, 8'd4, 1'b0);
    wait_idle("mid_idle");
    @(posedge clock); #1;
    check("mid_pre_valid", byte_valid, 1'b1);
    pulse_reset();
    check("mid_byte_valid", byte_valid, 1'b0);
    check("mid_sym_ready", sym_ready, 1'b1);
    check("mid_blocks", blocks_done, 16'd0);
    check("mid_err", err_overflow, 1'b0);
    byte_ready = 1'b1;
    send_sym(9'h1C7, 8'd9, 8'h6D, 8'd7, 16'h002E, 8'd6, 8'h03, 8'd2, 1'b1);
    do_flush("mid");
    compare_stream("mid");
    check("mid_blocks_after", blocks_done, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
